// File: rtl/hci_core_mux_static_ctrl_pkg.sv
// Shared types for the static-mux control slice.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package hci_core_mux_static_ctrl_pkg;

  // Control FSM states: pass traffic, wait for responses, commit new selection.
  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    SWITCH = 2'd2
  } hci_mux_ctrl_state_e;

  // Width of a channel select, never narrower than one bit.
  function automatic int sel_width(input int nb_chan);
    return (nb_chan > 1) ? $clog2(nb_chan) : 1;
  endfunction

endpackage

// File: rtl/hci_outstanding_cnt.sv
// Up/down outstanding-transaction counter, saturating at MAX, sticky underflow flag.
// Latency: cnt/err update one cycle after inc/dec/clear.
// Backpressure: none; the caller must mask inc at MAX (saturation is only a safety net).
module hci_outstanding_cnt #(
  parameter int MAX   = 8,
  parameter int CNT_W = $clog2(MAX + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  input  logic             clear,
  output logic [CNT_W-1:0] cnt,
  output logic             err
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX);

  // Count grants up and completed responses down; a response with nothing
  // outstanding leaves the count at zero and latches the error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      err <= 1'b0;
    end else if (clear) begin
      cnt <= '0;
      err <= 1'b0;
    end else begin
      case ({inc, dec})
        2'b10: if (cnt != MAX_CNT) cnt <= cnt + CNT_W'(1);
        2'b01: begin
          if (cnt == '0) err <= 1'b1;
          else           cnt <= cnt - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/hci_core_mux_static_ctrl.sv
// Owns the static mux select; passes req/gnt through and only switches channel once nothing is outstanding.
// Latency: req/gnt pass-through is combinational; a switch with nothing in flight lands on sel_o two cycles after the handshake.
// Backpressure: req_o/gnt_o are masked while draining/switching or at MAX_OUTSTANDING; sel_ready_o is low outside RUN.
module hci_core_mux_static_ctrl
  import hci_core_mux_static_ctrl_pkg::*;
#(
  parameter int NB_CHAN         = 2,
  parameter int MAX_OUTSTANDING = 8,
  parameter int DEFAULT_SEL     = 0,
  parameter int SEL_W           = sel_width(NB_CHAN),
  parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic [SEL_W-1:0] sel_i,
  input  logic             sel_valid_i,
  output logic             sel_ready_o,
  output logic [SEL_W-1:0] sel_o,
  input  logic             req_i,
  output logic             gnt_o,
  output logic             req_o,
  input  logic             gnt_i,
  input  logic             r_valid_i,
  input  logic             r_ready_i,
  output logic             busy_o,
  output logic [CNT_W-1:0] outstanding_o,
  output logic             err_o
);

  localparam logic [SEL_W-1:0] DEF_SEL = SEL_W'(DEFAULT_SEL);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  hci_mux_ctrl_state_e state;
  logic [SEL_W-1:0]    sel_q;
  logic [SEL_W-1:0]    pend_sel;
  logic [CNT_W-1:0]    cnt;
  logic                open;
  logic                inc;
  logic                dec;
  logic                sel_ok;
  logic                drain_done;

  // Traffic only flows in RUN and below the outstanding limit.
  assign open  = (state == RUN) && (cnt < MAX_CNT);
  assign req_o = req_i & open;
  assign gnt_o = gnt_i & open;

  assign inc = req_o & gnt_i;
  assign dec = r_valid_i & r_ready_i;

  assign sel_ok = int'(sel_i) < NB_CHAN;

  // No grants can happen while draining, so the count reaches zero next
  // cycle if it is already zero or the last response completes now.
  assign drain_done = (cnt == '0) || ((cnt == CNT_W'(1)) && dec);

  assign sel_ready_o   = (state == RUN);
  assign busy_o        = (state != RUN);
  assign sel_o         = sel_q;
  assign outstanding_o = cnt;

  hci_outstanding_cnt #(
    .MAX   (MAX_OUTSTANDING),
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk   (clk_i),
    .rst   (rst_i),
    .inc   (inc),
    .dec   (dec),
    .clear (clear_i),
    .cnt   (cnt),
    .err   (err_o)
  );

  // Switch FSM: latch a differing valid request, drain in-flight responses, then commit sel.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= RUN;
      sel_q    <= DEF_SEL;
      pend_sel <= DEF_SEL;
    end else if (clear_i) begin
      state    <= RUN;
      sel_q    <= DEF_SEL;
      pend_sel <= DEF_SEL;
    end else begin
      case (state)
        RUN: begin
          if (sel_valid_i && sel_ok && (sel_i != sel_q)) begin
            pend_sel <= sel_i;
            state    <= DRAIN;
          end
        end
        DRAIN: begin
          if (drain_done) begin
            sel_q <= pend_sel;
            state <= SWITCH;
          end
        end
        SWITCH:  state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

  // Out-of-range switch requests are accepted but dropped; flag them in simulation.
  always @(posedge clk_i) begin
    if (!rst_i && !clear_i && (state == RUN) && sel_valid_i)
      assert (sel_ok)
      else $warning("hci_core_mux_static_ctrl: sel_i=%0d out of range, switch request ignored", sel_i);
  end

endmodule
